// File: rtl/aes_round_engine_pkg.sv
// Shared AES types, S-box tables and GF(2^8) helpers used by the folded round engine.
package AESDefinitions;

    typedef logic [127:0] state_t;
    typedef logic [127:0] roundKey_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } eng_state_e;

    // Zero flags an unsupported key length to the instantiating module.
    function automatic int NumRounds(input int key_bits);
        case (key_bits)
            128:     return 10;
            192:     return 12;
            256:     return 14;
            default: return 0;
        endcase
    endfunction

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] inv_sub_byte(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant; enough for every MixColumns coefficient.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gmul(a0, 4'd14) ^ gmul(a1, 4'd11) ^ gmul(a2, 4'd13) ^ gmul(a3, 4'd9),
                gmul(a0, 4'd9)  ^ gmul(a1, 4'd14) ^ gmul(a2, 4'd11) ^ gmul(a3, 4'd13),
                gmul(a0, 4'd13) ^ gmul(a1, 4'd9)  ^ gmul(a2, 4'd14) ^ gmul(a3, 4'd11),
                gmul(a0, 4'd11) ^ gmul(a1, 4'd13) ^ gmul(a2, 4'd9)  ^ gmul(a3, 4'd14)};
    endfunction

endpackage

// File: rtl/aes_round_engine_round_unit.sv
// Combinational single AES round, forward or inverse, with final-round MixColumns bypass.
module aes_round_unit
    import AESDefinitions::*;
(
    input  state_t    state_i,
    input  roundKey_t round_key_i,
    input  logic      decrypt_i,
    input  logic      final_i,
    output state_t    next_state_o
);

    state_t enc_sb;
    state_t enc_mix;
    state_t dec_sb;
    state_t dec_ark;
    state_t dec_mix;

    // Byte gi sits at row gi%4, column gi/4 (column-major, MSB first).
    for (genvar gi = 0; gi < 16; gi++) begin : g_byte
        localparam int COL     = gi / 4;
        localparam int ROW     = gi % 4;
        localparam int ENC_SRC = 4 * ((COL + ROW) % 4) + ROW;
        localparam int DEC_SRC = 4 * ((COL + 4 - ROW) % 4) + ROW;

        assign enc_sb[127-8*gi -: 8] = sub_byte(state_i[127-8*ENC_SRC -: 8]);
        assign dec_sb[127-8*gi -: 8] = inv_sub_byte(state_i[127-8*DEC_SRC -: 8]);
    end

    assign dec_ark = dec_sb ^ round_key_i;

    for (genvar gi = 0; gi < 4; gi++) begin : g_col
        assign enc_mix[127-32*gi -: 32] = mix_column(enc_sb[127-32*gi -: 32]);
        assign dec_mix[127-32*gi -: 32] = inv_mix_column(dec_ark[127-32*gi -: 32]);
    end

    assign next_state_o = decrypt_i ? (final_i ? dec_ark : dec_mix)
                                    : ((final_i ? enc_sb : enc_mix) ^ round_key_i);

endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES cipher/inverse cipher: one round per clock over a latched key schedule.
module aes_round_engine
    import AESDefinitions::*;
#(
    parameter  int KEY_BITS   = 128,
    localparam int NUM_ROUNDS = NumRounds(KEY_BITS)
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_decrypt,
    input  logic [127:0]                  in_block,
    input  logic [(NUM_ROUNDS+1)*128-1:0] in_round_keys,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [127:0]                  out_block,
    output logic                          busy
);

    if (NUM_ROUNDS == 0) begin : g_bad_key_bits
        $fatal(1, "aes_round_engine: KEY_BITS must be 128, 192 or 256");
    end

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    eng_state_e fsm_q;
    state_t     state_q;
    logic [3:0] round_q;
    logic       decrypt_q;
    logic       in_ready_q;
    logic       out_valid_q;
    logic       busy_q;
    roundKey_t  keys_q [NUM_ROUNDS+1];

    logic       accept;
    logic       final_round;
    logic [3:0] key_idx;
    roundKey_t  round_key;
    state_t     init_state_d;
    state_t     round_state_d;

    assign accept       = (fsm_q == ST_IDLE) && in_valid;
    assign init_state_d = in_block ^ (in_decrypt ? in_round_keys[128*NUM_ROUNDS +: 128]
                                                 : in_round_keys[127:0]);
    assign final_round  = (round_q == LAST_ROUND);
    // The inverse cipher walks the schedule from the top down.
    assign key_idx      = decrypt_q ? (LAST_ROUND - round_q) : round_q;
    assign round_key    = keys_q[key_idx];

    aes_round_unit u_round (
        .state_i      (state_q),
        .round_key_i  (round_key),
        .decrypt_i    (decrypt_q),
        .final_i      (final_round),
        .next_state_o (round_state_d)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i <= NUM_ROUNDS; i++) keys_q[i] <= '0;
        end else if (accept) begin
            for (int i = 0; i <= NUM_ROUNDS; i++) keys_q[i] <= in_round_keys[128*i +: 128];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q       <= ST_IDLE;
            state_q     <= '0;
            round_q     <= '0;
            decrypt_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        decrypt_q  <= in_decrypt;
                        state_q    <= init_state_d;
                        round_q    <= 4'd1;
                        fsm_q      <= ST_ROUND;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_ROUND: begin
                    state_q <= round_state_d;
                    if (final_round) begin
                        fsm_q       <= ST_DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        round_q <= round_q + 4'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        fsm_q       <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    fsm_q       <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_block = state_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_aes_round_engine.sv
// Directed known-answer bench for aes_round_engine with 128/192/256-bit instances.
module tb_aes_round_engine;

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic            clock = 1'b0;
    logic            reset_n = 1'b1;
    logic            in_decrypt;
    logic [127:0]    in_block;
    logic [1919:0]   keys_bus;
    logic            out_ready;
    logic            iv [3];
    logic            ir [3];
    logic            ov [3];
    logic            bz [3];
    logic [127:0]    ob [3];

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        aes_round_engine #(.KEY_BITS(128 + 64 * gi)) dut (
            .clock         (clock),
            .reset_n       (reset_n),
            .in_valid      (iv[gi]),
            .in_ready      (ir[gi]),
            .in_decrypt    (in_decrypt),
            .in_block      (in_block),
            .in_round_keys (keys_bus[(11+2*gi)*128-1:0]),
            .out_valid     (ov[gi]),
            .out_ready     (out_ready),
            .out_block     (ob[gi]),
            .busy          (bz[gi])
        );
    end

    function automatic logic [7:0] gf_x2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {AESDefinitions::sub_byte(w[31:24]), AESDefinitions::sub_byte(w[23:16]),
                AESDefinitions::sub_byte(w[15:8]),  AESDefinitions::sub_byte(w[7:0])};
    endfunction

    // Software key expansion for the key 00 01 02 ... of the given length.
    function automatic logic [1919:0] expand(input int kb);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] ks;
        int nk;
        int nr;
        nk = kb / 32;
        nr = nk + 6;
        rc = 8'h01;
        ks = '0;
        for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gf_x2(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int k = 0; k <= nr; k++) ks[128*k +: 128] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
        return ks;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_wait(input int idx, input logic dec, input logic [127:0] blk,
                              input bit scramble, output int lat);
        in_block   = blk;
        in_decrypt = dec;
        iv[idx]    = 1'b1;
        @(posedge clock); #1;
        iv[idx] = 1'b0;
        if (scramble) begin
            in_block   = ~blk;
            in_decrypt = ~dec;
            keys_bus   = ~keys_bus;
            iv[idx]    = 1'b1;
        end
        lat = 1;
        while (ov[idx] !== 1'b1 && lat < 64) begin
            @(posedge clock); #1;
            lat++;
            iv[idx] = 1'b0;
        end
    endtask

    task automatic run_vec(input int idx, input int nr, input logic dec, input logic [127:0] blk,
                           input logic [127:0] exp, input string tag, input bit scramble);
        int lat;
        check({tag, "_in_ready"}, 128'(ir[idx]), 128'd1);
        start_wait(idx, dec, blk, scramble, lat);
        check({tag, "_latency"}, 128'(lat), 128'(nr + 1));
        check({tag, "_block"}, ob[idx], exp);
        check({tag, "_busy"}, 128'(bz[idx]), 128'd1);
        @(posedge clock); #1;
        check({tag, "_out_valid_drop"}, 128'(ov[idx]), 128'd0);
        check({tag, "_in_ready_back"}, 128'(ir[idx]), 128'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [127:0] held;
        for (int k = 0; k < 3; k++) iv[k] = 1'b0;
        in_block   = '0;
        in_decrypt = 1'b0;
        out_ready  = 1'b1;
        keys_bus   = expand(128);

        #1 reset_n = 1'b0;
        #2;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset%0d_in_ready", k), 128'(ir[k]), 128'd1);
            check($sformatf("reset%0d_out_valid", k), 128'(ov[k]), 128'd0);
            check($sformatf("reset%0d_busy", k), 128'(bz[k]), 128'd0);
            check($sformatf("reset%0d_out_block", k), ob[k], 128'd0);
        end
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;

        run_vec(0, 10, 1'b0, PT, CT128, "aes128_enc", 1'b0);
        run_vec(0, 10, 1'b1, CT128, PT, "aes128_dec", 1'b0);
        keys_bus = expand(192);
        run_vec(1, 12, 1'b0, PT, CT192, "aes192_enc", 1'b0);
        run_vec(1, 12, 1'b1, CT192, PT, "aes192_dec", 1'b0);
        keys_bus = expand(256);
        run_vec(2, 14, 1'b0, PT, CT256, "aes256_enc", 1'b0);
        run_vec(2, 14, 1'b1, CT256, PT, "aes256_dec", 1'b0);

        keys_bus = expand(128);
        run_vec(0, 10, 1'b0, PT, CT128, "post_accept_change", 1'b1);
        keys_bus   = expand(128);
        in_decrypt = 1'b0;

        out_ready = 1'b0;
        start_wait(0, 1'b0, PT, 1'b0, lat);
        check("bp_latency", 128'(lat), 128'd11);
        check("bp_block", ob[0], CT128);
        held = ob[0];
        for (int i = 0; i < 20; i++) begin
            iv[0]    = (i % 3 == 0);
            in_block = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clock); #1;
            check($sformatf("bp_hold%0d_block", i), ob[0], CT128);
            check($sformatf("bp_hold%0d_in_ready", i), 128'(ir[0]), 128'd0);
            check($sformatf("bp_hold%0d_out_valid", i), 128'(ov[0]), 128'd1);
        end
        iv[0]     = 1'b0;
        out_ready = 1'b1;
        @(posedge clock); #1;
        check("bp_release_out_valid", 128'(ov[0]), 128'd0);
        check("bp_release_in_ready", 128'(ir[0]), 128'd1);
        check("bp_release_busy", 128'(bz[0]), 128'd0);
        check("bp_release_block_kept", ob[0], held);

        in_block   = PT;
        in_decrypt = 1'b0;
        iv[0]      = 1'b1;
        @(posedge clock); #1;
        iv[0] = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check("midrst_busy_before", 128'(bz[0]), 128'd1);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_out_valid", 128'(ov[0]), 128'd0);
        check("midrst_in_ready", 128'(ir[0]), 128'd1);
        check("midrst_busy", 128'(bz[0]), 128'd0);
        check("midrst_out_block", ob[0], 128'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        run_vec(0, 10, 1'b0, PT, CT128, "after_reset_enc", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
